// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: next-PC select codes, RV32I opcodes, NOP word and fetch FSM states.
package instr_fetch_pkg;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_JAL  = 2'b01;
  localparam logic [1:0] PC_JALR = 2'b10;
  localparam logic [1:0] PC_BR   = 2'b11;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD,
    ST_ERR
  } fetch_state_t;

  // Only bit 1 matters: bit 0 is cleared for jalr and always zero for jal/branch immediates.
  function automatic logic target_misaligned(input logic [31:0] addr);
    return addr[1];
  endfunction

endpackage

// File: rtl/next_pc_gen.sv
// Combinational next-PC selection for the fetch stage; all adds wrap modulo 2^32.
module next_pc_gen
  import instr_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [31:0] imm_ext,
  input  logic [31:0] rs1_val,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4,
  output logic        misaligned
);

  logic [31:0] pc_imm;
  logic [31:0] rs1_imm;

  always_comb begin
    pc_plus4 = pc + 32'd4;
    pc_imm   = pc + imm_ext;
    rs1_imm  = rs1_val + imm_ext;
    next_pc  = pc_plus4;
    unique case (pc_src)
      PC_SEQ:  next_pc = pc_plus4;
      PC_JAL:  next_pc = pc_imm;
      PC_JALR: next_pc = {rs1_imm[31:1], 1'b0};
      PC_BR:   next_pc = branch_taken ? pc_imm : pc_plus4;
      default: next_pc = pc_plus4;
    endcase
  end

  assign misaligned = target_misaligned(next_pc);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: requests a word at pc, holds it for downstream, then redirects via next_pc_gen.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [31:0] imm_ext,
  input  logic [31:0] rs1_val,
  output logic        misalign_err
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         req_q, req_d;
  logic         vld_q, vld_d;
  logic         err_q, err_d;

  logic [31:0]  next_pc;
  logic         next_misaligned;
  logic         handshake;

  next_pc_gen u_next_pc_gen (
    .pc           (pc_q),
    .pc_src       (pc_src),
    .branch_taken (branch_taken),
    .imm_ext      (imm_ext),
    .rs1_val      (rs1_val),
    .next_pc      (next_pc),
    .pc_plus4     (pc_plus4),
    .misaligned   (next_misaligned)
  );

  assign handshake = vld_q & instr_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    req_d   = req_q;
    vld_d   = vld_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        req_d   = 1'b1;
      end
      ST_REQ: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = ST_HOLD;
          req_d   = 1'b0;
          vld_d   = 1'b1;
        end
      end
      ST_HOLD: begin
        // Redirect inputs are only meaningful in the retire cycle.
        if (handshake) begin
          pc_d    = next_pc;
          instr_d = NOP_INSTR;
          vld_d   = 1'b0;
          if (next_misaligned) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = ST_REQ;
            req_d   = 1'b1;
          end
        end
      end
      ST_ERR: begin
        req_d = 1'b0;
        vld_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign instr        = instr_q;
  assign instr_valid  = vld_q;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed fetch/retire sequence, checked by a negedge monitor.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  pc_src;
  logic        branch_taken;
  logic [31:0] imm_ext;
  logic [31:0] rs1_val;
  logic        misalign_err;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .pc_src       (pc_src),
    .branch_taken (branch_taken),
    .imm_ext      (imm_ext),
    .rs1_val      (rs1_val),
    .misalign_err (misalign_err)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } hold_t;

  hold_t       hold_q[$];
  logic [31:0] addr_q[$];
  int          checks   = 0;
  int          failures = 0;
  bit          prev_vld = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  // Monitor: memory handshakes pop the address queue, each new held instruction pops the hold queue.
  always @(negedge clk) begin
    if (imem_req && imem_rvalid) begin
      if (addr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL fetch_addr_unexpected actual=%h expected=none", imem_addr);
      end else begin
        chk("fetch_addr", imem_addr, addr_q.pop_front());
      end
    end
    if (instr_valid && !prev_vld) begin
      if (hold_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL hold_unexpected actual=%h expected=none", instr);
      end else begin
        hold_t e;
        e = hold_q.pop_front();
        chk("hold_instr", instr, e.instr);
        chk("hold_pc", pc, e.pc);
        chk("hold_pc_plus4", pc_plus4, e.pc4);
      end
    end
    prev_vld = instr_valid;
  end

  task automatic junk_ctrl();
    pc_src       = 2'($urandom);
    branch_taken = 1'($urandom);
    imm_ext      = $urandom;
    rs1_val      = $urandom;
  endtask

  // Called when the DUT should be in (or about to enter) REQ; answers after lat idle cycles.
  task automatic fetch(input logic [31:0] data, input int lat, input logic [31:0] exp_addr);
    int n = 0;
    int req_cycles = 0;
    while (!imem_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!imem_req) begin
      checks++;
      failures++;
      $display("FAIL req_timeout actual=0 expected=1");
      return;
    end
    for (int i = 0; i < lat; i++) begin
      if (imem_req) req_cycles++;
      @(posedge clk); #1;
    end
    if (imem_req) req_cycles++;
    addr_q.push_back(exp_addr);
    hold_q.push_back(hold_t'{instr: data, pc: exp_addr, pc4: exp_addr + 32'd4});
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    if (lat > 0) chk("req_hold_cycles", req_cycles, lat + 1);
    chk1("req_drop_after_resp", imem_req, 1'b0);
  endtask

  task automatic retire(input logic [1:0] src, input logic taken, input logic [31:0] imm,
                        input logic [31:0] rs1, input int stall);
    chk1("hold_valid", instr_valid, 1'b1);
    for (int i = 0; i < stall; i++) begin
      instr_ready = 1'b0;
      junk_ctrl();
      @(posedge clk); #1;
    end
    pc_src       = src;
    branch_taken = taken;
    imm_ext      = imm;
    rs1_val      = rs1;
    instr_ready  = 1'b1;
    @(posedge clk); #1;
    instr_ready = 1'b0;
    junk_ctrl();
  endtask

  initial begin
    rst          = 1'b1;
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'h0;
    instr_ready  = 1'b0;
    pc_src       = PC_SEQ;
    branch_taken = 1'b0;
    imm_ext      = 32'h0;
    rs1_val      = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk1("rst_err", misalign_err, 1'b0);

    rst = 1'b0;
    chk1("idle_no_req", imem_req, 1'b0);
    @(posedge clk); #1;
    chk1("first_req", imem_req, 1'b1);
    fetch(32'h0050_0093, 0, 32'h0);

    // Stall in HOLD while memory noise is driven.
    for (int i = 0; i < 5; i++) begin
      imem_rvalid = i[0];
      imem_rdata  = $urandom;
      @(posedge clk); #1;
      chk("stall_instr", instr, 32'h0050_0093);
      chk("stall_pc", pc, 32'h0);
      chk1("stall_valid", instr_valid, 1'b1);
    end
    imem_rvalid = 1'b0;

    retire(PC_SEQ, 1'b0, 32'h0, 32'h0, 0);
    chk1("zero_wait_req", imem_req, 1'b1);
    fetch(32'h0000_0113, 0, 32'h4);
    retire(PC_JALR, 1'b0, 32'h4, 32'h2001, 1);
    fetch(32'h0000_0193, 3, 32'h2004);
    retire(PC_JAL, 1'b0, 32'hFFFF_E0FC, 32'h0, 0);
    fetch(32'h0000_0213, 0, 32'h100);
    retire(PC_JAL, 1'b0, 32'hFFFF_FFF0, 32'h0, 2);
    fetch(32'h0000_0293, 0, 32'hF0);
    retire(PC_BR, 1'b1, 32'hFFFF_FF50, 32'h0, 0);
    fetch(32'h0000_0313, 1, 32'h40);
    retire(PC_BR, 1'b0, 32'h80, 32'h0, 0);
    fetch(32'h0000_0393, 0, 32'h44);
    retire(PC_JAL, 1'b0, 32'hFFFF_FFB8, 32'h0, 0);
    fetch(32'h0000_0413, 0, 32'hFFFF_FFFC);
    retire(PC_SEQ, 1'b0, 32'h0, 32'h0, 0);
    chk1("wrap_no_err", misalign_err, 1'b0);
    fetch(32'h0000_0493, 0, 32'h0);

    retire(PC_JAL, 1'b0, 32'h2, 32'h0, 0);
    chk1("misalign_set", misalign_err, 1'b1);
    chk("misalign_pc", pc, 32'h2);
    chk("misalign_instr", instr, 32'h0000_0013);
    for (int i = 0; i < 8; i++) begin
      imem_rvalid = ~i[0];
      instr_ready = i[1];
      @(posedge clk); #1;
      chk1("err_no_req", imem_req, 1'b0);
      chk1("err_no_valid", instr_valid, 1'b0);
      chk1("err_sticky", misalign_err, 1'b1);
    end
    imem_rvalid = 1'b0;
    instr_ready = 1'b0;

    rst = 1'b1;
    @(posedge clk); #1;
    chk1("err_cleared", misalign_err, 1'b0);
    rst = 1'b0;
    fetch(32'h0000_0513, 0, 32'h0);
    retire(PC_SEQ, 1'b0, 32'h0, 32'h0, 0);
    chk("req_addr_before_rst", imem_addr, 32'h4);

    // Reset mid-request with a stale response that lingers into IDLE.
    #2;
    rst         = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0BAD_0BAD;
    #1;
    chk1("async_rst_req", imem_req, 1'b0);
    chk("async_rst_addr", imem_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    chk1("stale_dropped", instr_valid, 1'b0);
    chk1("restart_req", imem_req, 1'b1);
    chk("restart_addr", imem_addr, 32'h0);
    fetch(32'h00A0_0093, 0, 32'h0);
    retire(PC_SEQ, 1'b0, 32'h0, 32'h0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("addr_q_empty", addr_q.size(), 32'd0);
    chk("hold_q_empty", hold_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0): instr value while no valid instruction is held.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 imem_req  out  1  fetch request to instruction memory.
REQ-006 imem_addr  out  32  fetch address; equals pc.
REQ-007 imem_rvalid  in  1  instruction memory response valid.
REQ-008 imem_rdata  in  32  instruction word, valid with imem_rvalid.
REQ-009 instr  out  32  held instruction to decode/execute.
REQ-010 pc  out  32  address of held instruction.
REQ-011 pc_plus4  out  32  pc+4, the link value for jal/jalr.
REQ-012 instr_valid  out  1  instr/pc are valid.
REQ-013 instr_ready  in  1  downstream retires held instruction this cycle.
REQ-014 pc_src  in  2  next-PC select from control decode: 00 seq, 01 jal, 10 jalr, 11 branch.
REQ-015 branch_taken  in  1  branch condition result; used only when pc_src=11.
REQ-016 imm_ext  in  32  sign-extended immediate of held instruction.
REQ-017 rs1_val  in  32  rs1 operand, used for jalr.
REQ-018 misalign_err  out  1  sticky: a redirect target was not 4-byte aligned.

Function
REQ-019 FSM states SHALL be IDLE, REQ, HOLD, ERR.
REQ-020 IDLE SHALL go to REQ on the next clock unconditionally.
REQ-021 In REQ, imem_req SHALL be 1; when imem_rvalid=1 (including the first REQ cycle), instr SHALL latch imem_rdata and the state SHALL go to HOLD.
REQ-022 imem_rvalid SHALL be ignored in every state except REQ.
REQ-023 In HOLD, instr_valid SHALL be 1 and instr/pc SHALL be stable until instr_valid&instr_ready.
REQ-024 On instr_valid&instr_ready, pc SHALL load next_pc, instr SHALL load NOP_INSTR, and the state SHALL go to REQ.
REQ-025 next_pc: 00 -> pc+4; 01 -> pc+imm_ext; 10 -> (rs1_val+imm_ext) with bit 0 cleared; 11 -> pc+imm_ext if branch_taken, else pc+4.
REQ-026 pc_src, branch_taken, imm_ext, and rs1_val SHALL be sampled only in the handshake cycle.
REQ-027 All adds SHALL be 32-bit modulo 2^32 (pc 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no error).
REQ-028 If next_pc[1] is 1 at handshake, misalign_err SHALL set, pc SHALL load that target, and the state SHALL go to ERR.
REQ-029 ERR SHALL hold imem_req=0 and instr_valid=0 until reset.
REQ-030 With zero-wait memory, throughput SHALL be one instruction per 2 cycles; first imem_req SHALL assert the cycle after reset release.

Reset
REQ-031 Asserting rst SHALL immediately give: state IDLE, pc=RESET_PC, instr=NOP_INSTR, instr_valid=0, imem_req=0, misalign_err=0.
REQ-032 Reset during REQ SHALL abandon the outstanding request; any stale imem_rvalid SHALL be dropped per REQ-022.

Structure
REQ-033 A shared package SHALL hold the pc_src encodings (PC_SEQ, PC_JAL, PC_JALR, PC_BR), the opcode constants used by control decode, the NOP constant, and the fetch state enum.
REQ-034 Next-PC arithmetic SHALL be one combinational sub-module, next_pc_gen; the FSM and registers stay in instr_fetch.

Verification
REQ-035 Reset release, rvalid same cycle as req, rdata=32'h00500093 -> imem_addr=0, then instr_valid=1, instr=32'h00500093, pc=0, pc_plus4=4.
REQ-036 pc=32'h100, pc_src=01, imm_ext=32'hFFFFFFF0, handshake -> next imem_addr=32'hF0.
REQ-037 pc_src=10, rs1_val=32'h2001, imm_ext=4, handshake -> imem_addr=32'h2004; pc_src=11, branch_taken=0 at pc=32'h40 -> 32'h44.
REQ-038 instr_ready=0 for 5 cycles in HOLD while imem_rdata toggles -> instr/pc unchanged; rvalid=3 cycles late -> imem_req held 4 cycles.
REQ-039 pc=32'hFFFFFFFC, pc_src=00 -> imem_addr=0; pc_src=01, imm_ext=32'h2 -> misalign_err=1, ERR, no further imem_req until rst.
REQ-040 rst asserted mid-REQ, then rvalid pulsed during IDLE -> pulse ignored; fetch restarts at RESET_PC.
